fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 146 ++++++++++++++
 tb/tb_fetch_queue.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch unit. It issues one word read at a time to
// instruction memory and buffers the returned words with their fetch address + 4
// in a small FIFO that feeds the IF/ID register. A redirect from ID flushes the
// FIFO. A redirect that lands while a read is still in flight forces a drain
// state, where the stale response is absorbed.
//
// State  | meaning
// -------+------------------------------------------------------------------
// IDLE   | no request; FIFO full, or waiting one cycle after a redirect/drain
// REQ    | request at fetch_pc outstanding; an ack pushes the returned word
// DRAIN  | stale request outstanding after a redirect; its data is dropped
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   imem_req, imem_addr      instruction memory read request / word address
//   imem_ack, imem_rdata     memory response strobe / data
//   id_ready                 IF/ID accepts the head entry this cycle
//   redirect, redirect_pc    taken branch/jump from ID and its target
//   if_valid, if_instr,      head entry valid / instruction / fetch address + 4
//   if_pc4
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        id_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc4
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN} state_t;

  state_t          r_state;
  logic            r_imem_req;
  logic [31:0]     r_fetch_pc;
  logic [31:2]     r_addr;
  logic [CW-1:0]   r_count;
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [31:0]     r_instr_mem [DEPTH];
  logic [31:0]     r_pc4_mem   [DEPTH];

  state_t          w_state_next;
  logic [31:0]     w_pc_next;
  logic [CW-1:0]   w_count_next;
  logic            w_push;
  logic            w_pop;

  assign w_push = (r_state == S_REQ) && imem_ack && !redirect;
  assign w_pop  = (r_count != '0) && id_ready && !redirect;

  always_comb begin
    w_count_next = '0;
    if (!redirect) begin
      w_count_next = r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_fetch_pc;
    case (r_state)
      S_IDLE: begin
        if (redirect) begin
          w_pc_next = redirect_pc;
        end else if (r_count < CW'(DEPTH)) begin
          w_state_next = S_REQ;
        end
      end
      S_REQ: begin
        if (redirect) begin
          w_pc_next    = redirect_pc;
          w_state_next = imem_ack ? S_IDLE : S_DRAIN;
        end else if (imem_ack) begin
          w_pc_next    = r_fetch_pc + 32'd4;
          w_state_next = (w_count_next < CW'(DEPTH)) ? S_REQ : S_IDLE;
        end
      end
      S_DRAIN: begin
        if (redirect) begin
          w_pc_next = redirect_pc;
        end
        // An ack coinciding with a redirect still retires the stale request;
        // waiting for another ack here would hang.
        if (imem_ack) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_imem_req <= 1'b0;
      r_fetch_pc <= RESET_PC;
      r_addr     <= RESET_PC[31:2];
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else begin
      r_state    <= w_state_next;
      r_imem_req <= (w_state_next != S_IDLE);
      r_fetch_pc <= w_pc_next;
      // The request address tracks fetch_pc, except that the in-flight
      // address is frozen while a stale request drains.
      if (w_state_next != S_DRAIN) begin
        r_addr <= w_pc_next[31:2];
      end
      r_count <= w_count_next;
      if (redirect) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + AW'(1);
        if (w_pop)  r_rptr <= r_rptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      r_instr_mem[r_wptr] <= imem_rdata;
      r_pc4_mem[r_wptr]   <= r_fetch_pc + 32'd4;
    end
  end

  assign imem_req  = r_imem_req;
  assign imem_addr = {r_addr, 2'b00};
  assign if_valid  = (r_count != '0);
  assign if_instr  = r_instr_mem[r_rptr];
  assign if_pc4    = r_pc4_mem[r_rptr];

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH 4, RESET_PC 0). Inputs are driven 1 ns
// after each rising edge; outputs depend only on registered state and are
// checked at the same point.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc4;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .id_ready    (id_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc4      (if_pc4)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; imem_ack = 1'b0; id_ready = 1'b0; redirect = 1'b0;
    redirect_pc = '0; imem_rdata = '0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; id_ready = 1'b0;
    redirect = 1'b0; redirect_pc = '0;
    tick();
    tick();
    chk("rst_req",   imem_req, 0);
    chk("rst_valid", if_valid, 0);
    rst_n = 1'b1;
    tick();
    chk("first_req",  imem_req, 1);
    chk("first_addr", imem_addr, 32'h0);

    // Streaming: ack and id_ready every cycle.
    imem_ack = 1'b1; id_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("strm_addr_pre", imem_addr, 32'(4 * k));
      imem_rdata = 32'hA000_0000 + 32'(k);
      tick();
      chk("strm_valid", if_valid, 1);
      chk("strm_pc4",   if_pc4, 32'(4 * (k + 1)));
      chk("strm_instr", if_instr, 32'hA000_0000 + 32'(k));
      chk("strm_req",   imem_req, 1);
    end

    // Fill to DEPTH with id_ready low.
    do_reset();
    imem_ack = 1'b1; id_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("fill_req",  imem_req, 1);
      chk("fill_addr", imem_addr, 32'(4 * k));
      imem_rdata = 32'hB000_0000 + 32'(k);
      tick();
    end
    chk("full_req",   imem_req, 0);
    chk("full_valid", if_valid, 1);
    chk("full_pc4",   if_pc4, 32'h4);
    chk("full_instr", if_instr, 32'hB000_0000);
    imem_ack = 1'b0;
    tick();
    chk("full_hold_req", imem_req, 0);
    id_ready = 1'b1;
    tick();
    chk("pop_req",   imem_req, 0);
    chk("pop_pc4",   if_pc4, 32'h8);
    chk("pop_instr", if_instr, 32'hB000_0001);
    id_ready = 1'b0;
    tick();
    chk("refill_req",  imem_req, 1);
    chk("refill_addr", imem_addr, 32'h10);
    tick();
    tick();
    chk("wait_addr_stable", imem_addr, 32'h10);
    chk("wait_req_stable",  imem_req, 1);
    imem_ack = 1'b1; imem_rdata = 32'hB000_0004;
    tick();
    chk("refull_req", imem_req, 0);
    imem_ack = 1'b0;

    // Redirect while a request waits for its ack.
    do_reset();
    tick();
    redirect = 1'b1; redirect_pc = 32'h400;
    tick();
    redirect = 1'b0;
    chk("drain_req",  imem_req, 1);
    chk("drain_addr", imem_addr, 32'h0);
    tick();
    chk("drain_addr2", imem_addr, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    chk("drain_done_req",   imem_req, 0);
    chk("drain_done_valid", if_valid, 0);
    tick();
    chk("after_drain_req",  imem_req, 1);
    chk("after_drain_addr", imem_addr, 32'h400);

    // Redirect coinciding with ack and pop, two entries queued.
    do_reset();
    imem_ack = 1'b1; imem_rdata = 32'hD000_0000;
    tick();
    imem_rdata = 32'hD000_0001;
    tick();
    chk("two_valid", if_valid, 1);
    redirect = 1'b1; redirect_pc = 32'h80; id_ready = 1'b1;
    imem_rdata = 32'hD000_0002;
    tick();
    chk("redir_ack_valid", if_valid, 0);
    chk("redir_ack_req",   imem_req, 0);
    redirect = 1'b0; id_ready = 1'b0; imem_ack = 1'b0;
    tick();
    chk("redir_ack_next_req",  imem_req, 1);
    chk("redir_ack_next_addr", imem_addr, 32'h80);
    imem_ack = 1'b1; imem_rdata = 32'hD000_0003;
    tick();
    imem_ack = 1'b0;
    chk("redir_push_pc4",   if_pc4, 32'h84);
    chk("redir_push_instr", if_instr, 32'hD000_0003);

    // Address wrap, reached via a redirect while IDLE.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    chk("idle_redir_req", imem_req, 0);
    redirect = 1'b0;
    tick();
    chk("wrap_addr_pre", imem_addr, 32'hFFFF_FFFC);
    imem_ack = 1'b1; imem_rdata = 32'hE000_0000;
    tick();
    imem_ack = 1'b0;
    chk("wrap_pc4",   if_pc4, 32'h0);
    chk("wrap_valid", if_valid, 1);
    chk("wrap_addr",  imem_addr, 32'h0);

    // Reset in DRAIN, then a stray ack.
    do_reset();
    redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    chk("pre_rst_drain_addr", imem_addr, 32'h0);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_req",   imem_req, 0);
    chk("mid_rst_valid", if_valid, 0);
    rst_n = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hF000_0000;
    tick();
    imem_ack = 1'b0;
    chk("stray_valid", if_valid, 0);
    chk("stray_req",   imem_req, 1);
    chk("stray_addr",  imem_addr, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
